gray_fifo_ptr_ctrl: RTL and testbench
=====================================

# gray_fifo_ptr_ctrl

Single-clock FIFO pointer controller that sequences writes and reads into an external dual-port RAM of depth 2^ADDR_W. It holds (ADDR_W+1)-bit binary read/write pointers, derives registered Gray-coded copies using g = b ^ (b >> 1), and generates full/empty/count status. The Gray pointers are the hand-off point for a later clock-domain-crossing stage, so each one changes by exactly one bit per accepted operation.

## Interface
- ADDR_W, 4, RAM address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
- ALMOST_THR, 2, almost_full/almost_empty threshold in entries; legal range 1..2^ADDR_W-1.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- mem_we  output  1  RAM write strobe; combinational, = wr_en & ~full.
- mem_wr_addr  output  ADDR_W  = wr_ptr_bin[ADDR_W-1:0].
- mem_rd_addr  output  ADDR_W  = rd_ptr_bin[ADDR_W-1:0].
- wr_ptr_gray  output  ADDR_W+1  registered Gray code of the write pointer.
- rd_ptr_gray  output  ADDR_W+1  registered Gray code of the read pointer.
- count  output  ADDR_W+1  registered occupancy, 0..2^ADDR_W.
- full  output  1  registered; count == 2^ADDR_W.
- empty  output  1  registered; count == 0.
- almost_full  output  1  registered; count >= 2^ADDR_W - ALMOST_THR. Present only with FIFO_ALMOST_EN.
- almost_empty  output  1  registered; count <= ALMOST_THR. Present only with FIFO_ALMOST_EN.
- overflow  output  1  one-cycle pulse when a write is rejected.
- underflow  output  1  one-cycle pulse when a read is rejected.

## Operation
- Write is accepted when wr_en & ~full. Read is accepted when rd_en & ~empty. full and empty are the registered values present before the edge.
- On an accepted write, wr_ptr_bin increments by 1. On an accepted read, rd_ptr_bin increments by 1. Both pointers wrap modulo 2^(ADDR_W+1).
- The Gray registers load bin2gray(next binary pointer) on the same edge as the binary pointers. They never lag the binary pointers by a cycle.
- count_next = wr_ptr_next - rd_ptr_next, computed in ADDR_W+1 bits modulo arithmetic. full, empty and the almost flags are registered from count_next.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
- When full, a simultaneous read and write accepts only the read. count decrements and overflow pulses.
- When empty, a simultaneous read and write accepts only the write. count increments and underflow pulses.
- The read data path is external. The RAM drives data for mem_rd_addr; this block adds no read latency.
- Reset (asynchronous, at any time, including mid-burst) clears all pointers and Gray registers to 0 and count to 0. It sets empty=1, full=0, overflow=0, underflow=0, almost_empty=1, almost_full=0.

## Timing
- mem_we, mem_wr_addr and mem_rd_addr are combinational from current state and wr_en.
- All other outputs are registered and reflect an operation one cycle after the accepting edge.
- wr_ptr_gray and rd_ptr_gray change in exactly one bit per increment, including the wrap from 2^(ADDR_W+1)-1 to 0.
- overflow and underflow assert for exactly the one cycle after the rejecting edge.

## Configuration
- FIFO_ALMOST_EN is the single compile-time option.
- Defined: the almost_full and almost_empty ports and their registers exist, with the thresholds above.
- Undefined: neither the ports nor their logic exist. All other behaviour is identical.

## Test plan
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, both Gray pointers 5'b00000 (ADDR_W=4).
- 16 consecutive writes -> full=1 after the 16th edge, count=16, wr_ptr_gray=5'b11000 (bin 16), mem_wr_addr=0. A 17th write gives overflow=1 for one cycle with pointers unchanged.
- From full, drive rd_en and wr_en together for 1 cycle -> only the read is accepted, count=15, full=0, overflow pulses.
- From empty, drive rd_en alone -> underflow pulses, rd_ptr_gray stays 0. Then drive rd_en and wr_en together -> count=1, empty=0.
- Stream 40 simultaneous read/write cycles from count=3 -> count stays 3 throughout. Both Gray pointers wrap 31->0 (5'b10000->5'b00000), and the checker confirms a Hamming distance of 1 per step.
- Assert rst_n low mid-burst between clock edges -> outputs clear immediately to reset values, without waiting for a clock edge. With FIFO_ALMOST_EN and ALMOST_THR=2, filling to 14 sets almost_full=1, and draining to 2 sets almost_empty=1.

Source files
------------

// File: rtl/gray_fifo_ptr_ctrl.sv
// Single-clock FIFO pointer controller: binary + registered Gray pointers, count/full/empty status.
// Optional almost_full/almost_empty flags are built when FIFO_ALMOST_EN is defined.
module gray_fifo_ptr_ctrl #(
  parameter int ADDR_W     = 4,
  parameter int ALMOST_THR = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
`ifdef FIFO_ALMOST_EN
  output logic              almost_full,
  output logic              almost_empty,
`endif
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [ADDR_W:0] r_wr_bin, r_rd_bin, r_wr_gray, r_rd_gray, r_count;
  logic            r_full, r_empty, r_ovf, r_udf;
  logic            w_wr_acc, w_rd_acc;
  logic [ADDR_W:0] w_wr_nxt, w_rd_nxt, w_cnt_nxt;

  // Acceptance uses the registered flags, so full+rd+wr accepts only the read and vice versa.
  assign w_wr_acc  = wr_en & ~r_full;
  assign w_rd_acc  = rd_en & ~r_empty;
  assign w_wr_nxt  = r_wr_bin + {{ADDR_W{1'b0}}, w_wr_acc};
  assign w_rd_nxt  = r_rd_bin + {{ADDR_W{1'b0}}, w_rd_acc};
  assign w_cnt_nxt = w_wr_nxt - w_rd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bin  <= '0;
      r_rd_bin  <= '0;
      r_wr_gray <= '0;
      r_rd_gray <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      r_wr_bin  <= w_wr_nxt;
      r_rd_bin  <= w_rd_nxt;
      // Gray loads from the next binary value so it never lags the binary pointer.
      r_wr_gray <= bin2gray(w_wr_nxt);
      r_rd_gray <= bin2gray(w_rd_nxt);
      r_count   <= w_cnt_nxt;
      r_full    <= (w_cnt_nxt == DEPTH);
      r_empty   <= (w_cnt_nxt == '0);
      r_ovf     <= wr_en & r_full;
      r_udf     <= rd_en & r_empty;
    end
  end

`ifdef FIFO_ALMOST_EN
  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(ALMOST_THR);
  localparam logic [ADDR_W:0] AF_LVL = DEPTH - AE_LVL;

  logic r_afull, r_aempty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_afull  <= (w_cnt_nxt >= AF_LVL);
      r_aempty <= (w_cnt_nxt <= AE_LVL);
    end
  end

  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
`endif

  assign mem_we      = w_wr_acc;
  assign mem_wr_addr = r_wr_bin[ADDR_W-1:0];
  assign mem_rd_addr = r_rd_bin[ADDR_W-1:0];
  assign wr_ptr_gray = r_wr_gray;
  assign rd_ptr_gray = r_rd_gray;
  assign count       = r_count;
  assign full        = r_full;
  assign empty       = r_empty;
  assign overflow    = r_ovf;
  assign underflow   = r_udf;

endmodule

// File: tb/tb_gray_fifo_ptr_ctrl.sv
// Randomized + directed bench for gray_fifo_ptr_ctrl against an integer occupancy/pointer model.
// Almost-flag checks are compiled in when FIFO_ALMOST_EN is defined.
module tb_gray_fifo_ptr_ctrl;
  localparam int ADDR_W = 4;
  localparam int THR    = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PMOD   = 2 * DEPTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0, rd_en = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wr_addr, mem_rd_addr;
  logic [ADDR_W:0]   wr_ptr_gray, rd_ptr_gray, count;
  logic              full, empty, overflow, underflow;
`ifdef FIFO_ALMOST_EN
  logic              almost_full, almost_empty;
`endif

  gray_fifo_ptr_ctrl #(.ADDR_W(ADDR_W), .ALMOST_THR(THR)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
    .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray), .count(count),
    .full(full), .empty(empty),
`ifdef FIFO_ALMOST_EN
    .almost_full(almost_full), .almost_empty(almost_empty),
`endif
    .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  // Model: plain integer pointers and occupancy.
  int m_wp = 0, m_rp = 0, m_cnt = 0;
  bit m_ovf = 0, m_udf = 0;
  logic [ADDR_W:0] prev_wg = '0, prev_rg = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & (PMOD - 1);
  endfunction

  task automatic chk_regs();
    chk("count", count, m_cnt);
    chk("full", full, m_cnt == DEPTH);
    chk("empty", empty, m_cnt == 0);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
    chk("wr_gray", wr_ptr_gray, gray(m_wp));
    chk("rd_gray", rd_ptr_gray, gray(m_rp));
    chk("wr_addr", mem_wr_addr, m_wp % DEPTH);
    chk("rd_addr", mem_rd_addr, m_rp % DEPTH);
`ifdef FIFO_ALMOST_EN
    chk("almost_full", almost_full, m_cnt >= DEPTH - THR);
    chk("almost_empty", almost_empty, m_cnt <= THR);
`endif
  endtask

  task automatic model_reset();
    m_wp = 0; m_rp = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
    prev_wg = '0; prev_rg = '0;
  endtask

  // Called just after a negedge: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input bit w, input bit r);
    bit aw, ar;
    wr_en = w; rd_en = r;
    #1;
    chk("mem_we", mem_we, w && (m_cnt != DEPTH));
    aw = w && (m_cnt != DEPTH);
    ar = r && (m_cnt != 0);
    m_ovf = w && (m_cnt == DEPTH);
    m_udf = r && (m_cnt == 0);
    m_wp = (m_wp + int'(aw)) % PMOD;
    m_rp = (m_rp + int'(ar)) % PMOD;
    m_cnt = m_cnt + int'(aw) - int'(ar);
    @(posedge clk);
    @(negedge clk);
    chk_regs();
    chk("wr_gray_hd", $countones(wr_ptr_gray ^ prev_wg), int'(aw));
    chk("rd_gray_hd", $countones(rd_ptr_gray ^ prev_rg), int'(ar));
    prev_wg = wr_ptr_gray;
    prev_rg = rd_ptr_gray;
  endtask

  initial begin
    // Reset then idle 3 cycles.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk_regs();
    repeat (3) step(0, 0);

    // Fill to full, then a rejected 17th write.
    repeat (16) step(1, 0);
    chk("full_after16", full, 1);
    chk("wg_bin16", wr_ptr_gray, 5'b11000);
    chk("waddr_wrap", mem_wr_addr, 0);
    step(1, 0);
    chk("ovf_pulse", overflow, 1);
    step(0, 0);
    chk("ovf_clear", overflow, 0);

    // Full with rd+wr: only the read is accepted.
    step(1, 1);
    chk("full_rw_cnt", count, 15);
    chk("full_rw_ovf", overflow, 1);

    // Drain, then underflow, then rd+wr from empty.
    repeat (15) step(0, 1);
    step(0, 1);
    chk("udf_pulse", underflow, 1);
    chk("udf_rg", rd_ptr_gray, gray(16));
    step(1, 1);
    chk("empty_rw_cnt", count, 1);
    chk("empty_rw_empty", empty, 0);

    // Up to 3 entries, then 40 simultaneous cycles across the pointer wrap.
    repeat (2) step(1, 0);
    repeat (40) begin
      step(1, 1);
      chk("stream_cnt", count, 3);
    end

    // Asynchronous reset mid-burst, between clock edges.
    repeat (5) step(1, 0);
    wr_en = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk_regs();
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b0;
    chk_regs();

    // Fill to 14 and drain to 2 to cross the almost thresholds.
    repeat (14) step(1, 0);
    repeat (12) step(0, 1);

    // Random traffic with phases biased toward full, empty and balanced.
    for (int ph = 0; ph < 6; ph++) begin
      int pw, pr;
      pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      pr = 100 - pw;
      for (int i = 0; i < 80; i++)
        step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
